// File: rtl/ahb_resp_mux.sv
// AHB-Lite data-phase response mux with a built-in default slave.
// The address-phase HSEL is registered so each data phase is served by the slave addressed one phase earlier.

module ahb_resp_mux_lane #(
  parameter int DW = 32
) (
  input  logic          sel_i,
  input  logic [DW-1:0] rdata_i,
  input  logic          rdy_i,
  input  logic          resp_i,
  output logic [DW-1:0] rdata_o,
  output logic          rdy_o,
  output logic          resp_o
);
  // Masked contribution; the top ORs lanes together, so a deselected lane must read as zero.
  assign rdata_o = sel_i ? rdata_i : '0;
  assign rdy_o   = sel_i & rdy_i;
  assign resp_o  = sel_i & resp_i;
endmodule

module ahb_resp_mux #(
  parameter int NSLV            = 4,
  parameter int DW              = 32,
  parameter int ERR_ON_UNMAPPED = 1
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NSLV-1:0]    HSEL,
  input  logic [1:0]         HTRANS,
  input  logic [NSLV*DW-1:0] HRDATA_S,
  input  logic [NSLV-1:0]    HREADYOUT_S,
  input  logic [NSLV-1:0]    HRESP_S,
  output logic [DW-1:0]      HRDATA,
  output logic               HREADY,
  output logic               HRESP,
  output logic               MULTISEL_ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t              state_q, state_d;
  logic [NSLV-1:0]     dsel_q, dsel_d;
  logic                msel_q, msel_d;

  logic [NSLV-1:0]     hsel_low;
  logic                hsel_multi;
  logic                unmapped_act;
  logic                accept;
  logic                unused_htrans0;

  logic [NSLV-1:0][DW-1:0] lane_data;
  logic [NSLV-1:0]         lane_rdy;
  logic [NSLV-1:0]         lane_resp;
  logic [DW-1:0]           mux_data;

  assign unused_htrans0 = HTRANS[0];

  // Lowest set bit wins; x & (x-1) is nonzero exactly when more than one bit is set.
  assign hsel_low     = HSEL & (~HSEL + NSLV'(1));
  assign hsel_multi   = |(HSEL & (HSEL - NSLV'(1)));
  assign unmapped_act = HTRANS[1] && (HSEL == '0) && (ERR_ON_UNMAPPED != 0);
  assign accept       = HREADY;

  for (genvar g = 0; g < NSLV; g++) begin : g_lane
    ahb_resp_mux_lane #(.DW(DW)) u_lane (
      .sel_i   (dsel_q[g]),
      .rdata_i (HRDATA_S[g*DW +: DW]),
      .rdy_i   (HREADYOUT_S[g]),
      .resp_i  (HRESP_S[g]),
      .rdata_o (lane_data[g]),
      .rdy_o   (lane_rdy[g]),
      .resp_o  (lane_resp[g])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NSLV; i++) mux_data |= lane_data[i];
  end

  // Data-phase outputs: a selected slave owns the bus, otherwise the default slave does.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (|dsel_q) begin
      HRDATA = mux_data;
      HREADY = |lane_rdy;
      HRESP  = |lane_resp;
    end else begin
      case (state_q)
        ST_ERR1: begin
          HREADY = 1'b0;
          HRESP  = 1'b1;
        end
        ST_ERR2: begin
          HREADY = 1'b1;
          HRESP  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    dsel_d  = dsel_q;
    msel_d  = msel_q;
    if (accept) begin
      dsel_d = hsel_low;
      msel_d = msel_q | hsel_multi;
    end
    case (state_q)
      ST_IDLE: if (accept && unmapped_act) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = unmapped_act ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      dsel_q  <= '0;
      msel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
      msel_q  <= msel_d;
    end
  end

  assign MULTISEL_ERR = msel_q;

endmodule
